// File: rtl/lisnoc_vc_link_arbiter.sv
// rtl/lisnoc_vc_link_arbiter.sv - packet-granular round-robin arbiter sharing one link among VC flit streams
module lisnoc_vc_link_arbiter #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter logic [flit_type_width-1:0] FLIT_TYPE_HEADER  = 2'b01,
  parameter logic [flit_type_width-1:0] FLIT_TYPE_PAYLOAD = 2'b00,
  parameter logic [flit_type_width-1:0] FLIT_TYPE_LAST    = 2'b10,
  parameter logic [flit_type_width-1:0] FLIT_TYPE_SINGLE  = 2'b11,
  parameter int vchannels = 2,
  parameter int vc_width = 1,
  localparam int flit_width = flit_data_width + flit_type_width
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [vchannels*flit_width-1:0] flit_i,
  input  logic [vchannels-1:0]            valid_i,
  output logic [vchannels-1:0]            ready_for_input,
  output logic [flit_width-1:0]           flit_o,
  output logic                            valid_o,
  output logic [vc_width-1:0]             vc_o,
  input  logic                            ready_i,
  output logic                            protocol_err
);

  typedef enum logic {IDLE, SENDING} state_e;

  state_e                  state_q, state_d;
  logic [vc_width-1:0]     ptr_q, ptr_d, lock_q, lock_d, vc_q, vc_d, gnt;
  logic [flit_width-1:0]   flit_q, flit_d, sel_flit;
  logic                    valid_q, valid_d, err_q, err_d;
  logic                    can_load, found, sel_valid;
  logic [vc_width:0]       cand;

  function automatic logic [flit_type_width-1:0] ftype(input logic [flit_width-1:0] f);
    return f[flit_width-1 -: flit_type_width];
  endfunction

  function automatic logic is_head(input logic [flit_width-1:0] f);
    return (ftype(f) == FLIT_TYPE_HEADER) || (ftype(f) == FLIT_TYPE_SINGLE);
  endfunction

  function automatic logic [vc_width-1:0] next_vc(input logic [vc_width-1:0] v);
    return (v == vc_width'(vchannels - 1)) ? '0 : v + vc_width'(1);
  endfunction

  always_comb begin
    can_load        = !valid_q || ready_i;
    state_d         = state_q;
    ptr_d           = ptr_q;
    lock_d          = lock_q;
    err_d           = err_q;
    flit_d          = flit_q;
    vc_d            = vc_q;
    valid_d         = can_load ? 1'b0 : valid_q;
    ready_for_input = '0;
    found           = 1'b0;
    gnt             = '0;
    sel_flit        = '0;
    sel_valid       = 1'b0;
    cand            = '0;
    case (state_q)
      IDLE: begin
        for (int v = 0; v < vchannels; v++) begin
          if (valid_i[v] && !is_head(flit_i[v*flit_width +: flit_width])) err_d = 1'b1;
        end
        // Search order starts at the round-robin pointer and wraps modulo vchannels.
        for (int i = 0; i < vchannels; i++) begin
          cand = {1'b0, ptr_q} + (vc_width+1)'(i);
          if (cand >= (vc_width+1)'(vchannels)) cand = cand - (vc_width+1)'(vchannels);
          for (int v = 0; v < vchannels; v++) begin
            if (!found && cand == (vc_width+1)'(v) && valid_i[v] &&
                is_head(flit_i[v*flit_width +: flit_width])) begin
              found    = 1'b1;
              gnt      = vc_width'(v);
              sel_flit = flit_i[v*flit_width +: flit_width];
            end
          end
        end
        if (found && can_load) begin
          for (int v = 0; v < vchannels; v++) ready_for_input[v] = (gnt == vc_width'(v));
          flit_d  = sel_flit;
          vc_d    = gnt;
          valid_d = 1'b1;
          if (ftype(sel_flit) == FLIT_TYPE_SINGLE) begin
            ptr_d = next_vc(gnt);
          end else begin
            lock_d  = gnt;
            state_d = SENDING;
          end
        end
      end
      SENDING: begin
        for (int v = 0; v < vchannels; v++) begin
          if (lock_q == vc_width'(v)) begin
            ready_for_input[v] = can_load;
            sel_valid          = valid_i[v];
            sel_flit           = flit_i[v*flit_width +: flit_width];
          end
        end
        if (sel_valid && can_load) begin
          flit_d  = sel_flit;
          vc_d    = lock_q;
          valid_d = 1'b1;
          if (ftype(sel_flit) == FLIT_TYPE_LAST) begin
            state_d = IDLE;
            ptr_d   = next_vc(lock_q);
          end else if (is_head(sel_flit)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      flit_q  <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      flit_q  <= flit_d;
      vc_q    <= vc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign flit_o       = flit_q;
  assign valid_o      = valid_q;
  assign vc_o         = vc_q;
  assign protocol_err = err_q;

endmodule
